// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Fetches 16-bit instructions at PC, decodes opcode[15:12] and dispatches ALU
// ops to ALUFSM. Optional EXEC watchdog is built when FETCH_WDOG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] memAddr,
  output logic            memRead,
  input  logic [15:0]     memData,
  input  logic            memValid,
  output logic [15:0]     instruction,
  output logic            aluStart,
  input  logic            aluDone,
  input  logic            pcInc,
  output logic            halted,
  output logic            wdogErr
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [3:0]      c_OP_ALU  = 4'b1000;
  localparam logic [3:0]      c_OP_JMP  = 4'b0100;
  localparam logic [3:0]      c_OP_HALT = 4'b1111;
  localparam logic [PC_W-1:0] c_PC_ONE  = PC_W'(1);

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_instr;
  logic              r_mem_read;
  logic              r_alu_start;
  logic              r_halted;
  logic              r_inc_taken;
  logic              w_wdog_fire;
  logic              w_exec_exit;
  logic              w_pc_bump;

`ifdef FETCH_WDOG_EN
  localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_wdog_cnt;
  logic               r_wdog_err;

  assign w_wdog_fire = (r_state == S_EXEC) && (r_wdog_cnt == c_CNT_LAST) && !aluDone;
  assign wdogErr     = r_wdog_err;
`else
  assign w_wdog_fire = 1'b0;
  // Without the watchdog the flag folds to 0 for any legal TIMEOUT.
  assign wdogErr     = (TIMEOUT < 0);
`endif

  assign w_exec_exit = aluDone || w_wdog_fire;
  // A timeout advances PC only if ALUFSM has not already done so.
  assign w_pc_bump   = (pcInc || w_wdog_fire) && !r_inc_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_instr     <= '0;
      r_mem_read  <= 1'b0;
      r_alu_start <= 1'b0;
      r_halted    <= 1'b0;
      r_inc_taken <= 1'b0;
`ifdef FETCH_WDOG_EN
      r_wdog_cnt  <= '0;
      r_wdog_err  <= 1'b0;
`endif
    end else begin
      r_alu_start <= 1'b0;
      case (r_state)
        S_FETCH, S_WAIT: begin
          if (memValid) begin
            r_instr     <= memData;
            r_alu_start <= (memData[15:12] == c_OP_ALU);
            r_mem_read  <= 1'b0;
            r_state     <= S_DECODE;
          end else begin
            r_mem_read  <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_DECODE: begin
          case (r_instr[15:12])
            c_OP_ALU: begin
              r_inc_taken <= 1'b0;
`ifdef FETCH_WDOG_EN
              r_wdog_cnt  <= '0;
`endif
              r_state     <= S_EXEC;
            end
            c_OP_JMP: begin
              r_pc       <= r_instr[PC_W-1:0];
              r_mem_read <= 1'b1;
              r_state    <= S_FETCH;
            end
            c_OP_HALT: begin
              r_halted <= 1'b1;
              r_state  <= S_HALTED;
            end
            default: begin
              r_pc       <= r_pc + c_PC_ONE;
              r_mem_read <= 1'b1;
              r_state    <= S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          if (w_pc_bump) begin
            r_pc        <= r_pc + c_PC_ONE;
            r_inc_taken <= 1'b1;
          end
          if (w_exec_exit) begin
            r_mem_read <= 1'b1;
            r_state    <= S_FETCH;
          end
`ifdef FETCH_WDOG_EN
          if (w_wdog_fire) begin
            r_wdog_err <= 1'b1;
          end else if (!aluDone) begin
            r_wdog_cnt <= r_wdog_cnt + c_CNT_ONE;
          end
`endif
        end
        S_HALTED: begin
          r_halted   <= 1'b1;
          r_mem_read <= 1'b0;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign memAddr     = r_pc;
  assign memRead     = r_mem_read;
  assign instruction = r_instr;
  assign aluStart    = r_alu_start;
  assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for instr_fetch_unit: program-level reference model, variable
// latency memory, scripted ALUFSM responder and a per-cycle compare process.
module tb_instr_fetch_unit;
  localparam int TB_TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  memAddr;
  logic        memRead;
  logic [15:0] memData;
  logic        memValid;
  logic [15:0] instruction;
  logic        aluStart;
  logic        aluDone;
  logic        pcInc;
  logic        halted;
  logic        wdogErr;

  instr_fetch_unit #(.PC_W(8), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memRead(memRead),
    .memData(memData), .memValid(memValid), .instruction(instruction),
    .aluStart(aluStart), .aluDone(aluDone), .pcInc(pcInc),
    .halted(halted), .wdogErr(wdogErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program, ALU scripts (cycle numbers within EXEC, 0 = none) and memory config
  logic [15:0] mem [256];
  int          scr_p  [8];
  int          scr_p2 [8];
  int          scr_d  [8];
  int          lat;
  bit          patch_en;
  logic [7:0]  patch_addr;
  logic [15:0] patch_val;
  bit          spur_go;
  bit          chk_en;

  // Reference model results
  logic [7:0]  exp_addr [64];
  logic [15:0] exp_alu  [16];
  int          n_exp_fetch;
  int          n_exp_alu;
  logic [7:0]  exp_halt_pc;
  bit          exp_wdog;

  // Compare process state
  int fetch_idx, alu_idx, cyc, st_cyc;
  int rise_cyc [64];
  bit prev_rd, prev_st;

  int n_cmp;
  int n_bad;

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Walks the program instruction by instruction, producing the fetch trace.
  task automatic model_run();
    int          pc;
    int          si;
    bit          patched;
    logic [15:0] w;
    pc = 0; si = 0; patched = 0;
    n_exp_fetch = 0; n_exp_alu = 0; exp_wdog = 0; exp_halt_pc = 8'hEE;
    for (int step = 0; step < 60; step++) begin
      exp_addr[n_exp_fetch] = 8'(pc);
      n_exp_fetch++;
      w = (patch_en && pc == int'(patch_addr) && patched) ? patch_val : mem[pc];
      if (patch_en && pc == int'(patch_addr)) patched = 1;
      case (w[15:12])
        4'h8: begin
          exp_alu[n_exp_alu] = w;
          n_exp_alu++;
          if (scr_d[si] == 0) begin
            pc = (pc + 1) % 256;
            exp_wdog = 1;
          end else if ((scr_p[si] != 0 && scr_p[si] <= scr_d[si]) ||
                       (scr_p2[si] != 0 && scr_p2[si] <= scr_d[si])) begin
            pc = (pc + 1) % 256;
          end
          si++;
        end
        4'h4: pc = int'(w[7:0]);
        4'hF: begin
          exp_halt_pc = 8'(pc);
          return;
        end
        default: pc = (pc + 1) % 256;
      endcase
    end
  endtask

  // Memory: accepts a request while memRead is high, answers lat cycles later.
  initial begin : p_mem
    bit         pend;
    bit         m_patched;
    int         wcnt;
    logic [7:0] req_addr;
    memValid = 1'b0; memData = 16'h0; pend = 0; m_patched = 0; wcnt = 0; req_addr = 8'h0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        memValid = 1'b0; pend = 0; m_patched = 0;
        continue;
      end
      #1;
      memValid = 1'b0;
      if (pend) begin
        if (wcnt == 0) begin
          memValid = 1'b1;
          memData  = (patch_en && req_addr == patch_addr && m_patched) ? patch_val : mem[req_addr];
          if (patch_en && req_addr == patch_addr) m_patched = 1;
          pend = 0;
        end else begin
          wcnt--;
        end
      end else if (memRead) begin
        pend = 1; req_addr = memAddr; wcnt = lat - 1;
      end
    end
  end

  // ALUFSM stand-in: replays one script entry per aluStart pulse.
  initial begin : p_alu
    int si;
    int lim;
    pcInc = 1'b0; aluDone = 1'b0; si = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pcInc = 1'b0; aluDone = 1'b0; si = 0;
        continue;
      end
      #1;
      pcInc   = spur_go;
      aluDone = spur_go;
      if (aluStart) begin
        lim = (scr_d[si] == 0) ? TB_TIMEOUT : scr_d[si];
        for (int k = 1; k <= lim; k++) begin
          @(posedge clk); #1;
          pcInc   = (k == scr_p[si]) || (k == scr_p2[si]);
          aluDone = (k == scr_d[si]);
        end
        si++;
      end
    end
  end

  // Per-cycle comparison against the model trace.
  initial begin : p_cmp
    cyc = 0; fetch_idx = 0; alu_idx = 0; prev_rd = 0; prev_st = 0; st_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst || !chk_en) begin
        fetch_idx = 0; alu_idx = 0; prev_rd = 0; prev_st = 0;
        continue;
      end
      if (memRead && !prev_rd) begin
        rise_cyc[fetch_idx] = cyc;
        check_eq("fetch_addr", 32'(memAddr),
                 (fetch_idx < n_exp_fetch) ? 32'(exp_addr[fetch_idx]) : 32'hDEAD);
        if (fetch_idx < 63) fetch_idx++;
      end else if (memRead) begin
        check_eq("addr_stable", 32'(memAddr), 32'(exp_addr[fetch_idx-1]));
      end
      if (aluStart) begin
        check_eq("alustart_single", 32'(prev_st), 32'd0);
        check_eq("alu_instr", 32'(instruction),
                 (alu_idx < n_exp_alu) ? 32'(exp_alu[alu_idx]) : 32'hDEADBEEF);
        st_cyc = cyc;
        if (alu_idx < 15) alu_idx++;
      end
      if (halted) begin
        check_eq("halt_memread", 32'(memRead), 32'd0);
        check_eq("halt_pc", 32'(memAddr), 32'(exp_halt_pc));
      end
`ifndef FETCH_WDOG_EN
      check_eq("wdog_zero", 32'(wdogErr), 32'd0);
`endif
      prev_rd = memRead;
      prev_st = aluStart;
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    for (int i = 0; i < 8; i++) begin
      scr_p[i] = 0; scr_p2[i] = 0; scr_d[i] = 0;
    end
    lat = 1; patch_en = 0; patch_addr = 8'h0; patch_val = 16'h0;
  endtask

  task automatic start_test(input bit chk_rst);
    chk_en = 0;
    rst    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (chk_rst) begin
      check_eq("rst_pc", 32'(memAddr), 32'd0);
      check_eq("rst_memread", 32'(memRead), 32'd0);
      check_eq("rst_instr", 32'(instruction), 32'd0);
      check_eq("rst_alustart", 32'(aluStart), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_wdog", 32'(wdogErr), 32'd0);
    end
    model_run();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    chk_en = 1;
  endtask

  task automatic finish_test(input logic [7:0] halt_pc, input int n_alu, input bit wdog);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (halted) break;
    end
    check_eq("reached_halt", 32'(halted), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("fetch_count", 32'(fetch_idx), 32'(n_exp_fetch));
    check_eq("alu_count", 32'(alu_idx), 32'(n_alu));
    check_eq("halt_pc_lit", 32'(memAddr), 32'(halt_pc));
    check_eq("wdog_end", 32'(wdogErr), 32'(wdog));
  endtask

  initial begin : p_main
    n_cmp = 0; n_bad = 0; chk_en = 0; spur_go = 0; rst = 1'b0;
    clear_prog();

    // Reset pulse while a slow read is outstanding, then a clean rerun
    lat = 3; mem[0] = 16'h4010; mem[8'h10] = 16'hF000;
    start_test(1);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (memRead && memAddr == 8'h10) break;
    end
    @(posedge clk); #1;
    check_eq("pre_rst_addr", 32'(memAddr), 32'h10);
    check_eq("pre_rst_instr", 32'(instruction), 32'h4010);
    #1;
    chk_en = 0;
    rst = 1'b0;
    #1;
    check_eq("midrst_pc", 32'(memAddr), 32'd0);
    check_eq("midrst_memread", 32'(memRead), 32'd0);
    check_eq("midrst_instr", 32'(instruction), 32'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk_en = 1;
    finish_test(8'h10, 0, 0);

    // ALU dispatch with pcInc and aluDone together
    clear_prog();
    mem[0] = 16'b1000000001000010; mem[1] = 16'hF000;
    scr_p[0] = 1; scr_d[0] = 1;
    start_test(0);
    check_eq("model_alu_word", 32'(exp_alu[0]), 32'h8042);
    check_eq("model_next_addr", 32'(exp_addr[1]), 32'h01);
    finish_test(8'h01, 1, 0);

    // NOP then JMP, 3-cycle spacing between requests
    clear_prog();
    mem[0] = 16'h0000; mem[1] = 16'h4005; mem[5] = 16'hF000;
    start_test(0);
    finish_test(8'h05, 0, 0);
    check_eq("nop_gap", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
    check_eq("jmp_gap", 32'(rise_cyc[2] - rise_cyc[1]), 32'd3);

    // HALT, then spurious ALU handshakes
    clear_prog();
    start_test(0);
    finish_test(8'h00, 0, 0);
    spur_go = 1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("spur_pc", 32'(memAddr), 32'd0);
    check_eq("spur_halted", 32'(halted), 32'd1);
    check_eq("spur_memread", 32'(memRead), 32'd0);
    spur_go = 0;

    // JMP to the top address, NOP wraps PC to 0
    clear_prog();
    mem[0] = 16'h40FF; mem[8'hFF] = 16'h0000;
    patch_en = 1; patch_addr = 8'h00; patch_val = 16'hF000;
    start_test(0);
    check_eq("model_wrap", 32'(exp_addr[2]), 32'h00);
    finish_test(8'h00, 0, 0);
    check_eq("wrap_fetches", 32'(fetch_idx), 32'd3);

    // Slow memory, repeated pcInc, aluDone without pcInc, other opcode as NOP
    clear_prog();
    lat = 3;
    mem[0] = 16'h8123; scr_p[0] = 2; scr_p2[0] = 3; scr_d[0] = 4;
    mem[1] = 16'h8456; scr_p[1] = 0; scr_d[1] = 2;
    patch_en = 1; patch_addr = 8'h01; patch_val = 16'h3001;
    mem[2] = 16'hF000;
    start_test(0);
    finish_test(8'h02, 2, 0);

`ifdef FETCH_WDOG_EN
    // ALU never finishes: watchdog forces the next fetch
    clear_prog();
    mem[0] = 16'h8042; mem[1] = 16'hF000;
    start_test(0);
    finish_test(8'h01, 1, 1);
    check_eq("wdog_exec_len", 32'(rise_cyc[1] - st_cyc), 32'd17);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
